// File: rtl/boton_pkg.sv
// Shared types and constants for the multi-button debounce/arbiter controller.
package boton_pkg;

    // Arbiter states: waiting for a pending press, or offering one on the event port.
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    // Stability counter width; covers ESTABLE up to 15.
    localparam int CNT_W = 4;

    // Width of the event index: clog2 of the button count, never below 1 bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/boton_ctrl_if.sv
// Button pins, debounced levels and the valid/ready press-event port.
interface boton_ctrl_if #(
    parameter int N_BOTONES = 4
) ();
    localparam int ID_W = boton_pkg::id_w(N_BOTONES);

    logic [N_BOTONES-1:0] botones0;
    logic [N_BOTONES-1:0] botones;
    logic                 evento_valid;
    logic [ID_W-1:0]      evento_id;
    logic                 evento_ready;
    logic                 overrun;

    // Board/consumer side: drives raw pins and ready, observes levels and events.
    modport master (
        output botones0, evento_ready,
        input  botones, evento_valid, evento_id, overrun
    );

    // Controller side.
    modport slave (
        input  botones0, evento_ready,
        output botones, evento_valid, evento_id, overrun
    );
endinterface

// File: rtl/boton_filtro.sv
// One button: two-flop synchronizer, tick-driven stability counter, debounced level.
module boton_filtro
    import boton_pkg::*;
#(
    parameter int ESTABLE = 4
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic tick_i,
    input  logic raw_i,
    output logic nivel_o
);
    localparam logic [CNT_W-1:0] LIMITE = CNT_W'(ESTABLE);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             nivel_q;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Synchronize the pin, then flip the level after ESTABLE consecutive disagreeing ticks.
    always_ff @(posedge Clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
        if (!Reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            nivel_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            if (tick_i) begin
                if (sync2_q == nivel_q) begin
                    cnt_q <= '0;
                end else if (cnt_inc == LIMITE) begin
                    nivel_q <= ~nivel_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_inc;
                end
            end
        end
    end

    assign nivel_o = nivel_q;

endmodule

// File: rtl/boton_ctrl.sv
// N-button controller: shared sample prescaler, per-button filters, press edge
// detection, pending set and a fixed-priority (lowest index) event arbiter.
module boton_ctrl
    import boton_pkg::*;
#(
    parameter int N_BOTONES = 4,
    parameter int TICK_DIV  = 50000,
    parameter int ESTABLE   = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    boton_ctrl_if.slave bus
);
    localparam int                ID_W    = id_w(N_BOTONES);
    localparam int                PRE_W   = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]     pre_q;
    logic                 tick;
    logic [N_BOTONES-1:0] nivel;
    logic [N_BOTONES-1:0] botones_d_q;
    logic [N_BOTONES-1:0] rise;
    logic [N_BOTONES-1:0] pending_q;
    logic [N_BOTONES-1:0] pending_d;
    logic [N_BOTONES-1:0] clr;
    logic [ID_W-1:0]      sel_id;
    logic                 overrun_d;
    arb_state_t           state_q;
    logic                 valid_q;
    logic [ID_W-1:0]      id_q;
    logic                 overrun_q;

    // Free-running sample prescaler; nothing but reset realigns it.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    assign tick = (pre_q == PRE_MAX);

    for (genvar i = 0; i < N_BOTONES; i++) begin : g_filtro
        boton_filtro #(
            .ESTABLE (ESTABLE)
        ) u_filtro (
            .Clk     (Clk),
            .Reset_n (Reset_n),
            .tick_i  (tick),
            .raw_i   (bus.botones0[i]),
            .nivel_o (nivel[i])
        );
    end

    assign rise = nivel & ~botones_d_q;

    // Pick the lowest pending index and the bit IDLE retires when it starts an offer.
    always_comb begin
        // NOTE: defaults before any branch keep this purely combinational (no latches).
        sel_id = '0;
        clr    = '0;
        for (int i = N_BOTONES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_id = ID_W'(i);
            end
        end
        if (state_q == IDLE && pending_q != '0) begin
            clr[sel_id] = 1'b1;
        end
    end

    // A new rise always wins over the retire; a rise onto a still-set bit is a lost press.
    assign pending_d = (pending_q & ~clr) | rise;
    assign overrun_d = |(rise & pending_q & ~clr);

    // Edge history, pending set, overrun pulse and the offer/handshake FSM.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            botones_d_q <= '0;
            pending_q   <= '0;
            overrun_q   <= 1'b0;
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            id_q        <= '0;
        end else begin
            botones_d_q <= nivel;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            case (state_q)
                IDLE: begin
                    if (pending_q != '0) begin
                        id_q    <= sel_id;
                        valid_q <= 1'b1;
                        state_q <= OFFER;
                    end
                end
                OFFER: begin
                    if (bus.evento_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.botones      = nivel;
    assign bus.evento_valid = valid_q;
    assign bus.evento_id    = id_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_boton_ctrl.sv
// Self-checking bench for boton_ctrl: scenario tasks plus a cycle reference model
// built from the press/debounce/arbitration rules.
module tb_boton_ctrl;
    localparam int N   = 4;
    localparam int TD  = 4;
    localparam int EST = 3;
    localparam int IDW = 2;
    localparam int VW  = N + IDW + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #10 clk = ~clk;

    boton_ctrl_if #(.N_BOTONES(N)) bus ();

    boton_ctrl #(
        .N_BOTONES (N),
        .TICK_DIV  (TD),
        .ESTABLE   (EST)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    // Reference model state
    int             m_cyc;
    logic [N-1:0]   m_seen1, m_seen2;
    logic [N-1:0]   m_lvl, m_lvl_prev, m_pend;
    int             m_run [N];
    logic           m_valid;
    logic [IDW-1:0] m_id;
    logic           m_ovr;

    // Per-scenario tallies gathered while stepping
    int             mm_n, hs_n, ovr_n;
    logic [VW-1:0]  mm_got, mm_exp;
    time            mm_t;

    function automatic logic [VW-1:0] dut_vec();
        return {bus.botones, bus.evento_valid, bus.evento_id, bus.overrun};
    endfunction

    function automatic logic [VW-1:0] mdl_vec();
        return {m_lvl, m_valid, m_id, m_ovr};
    endfunction

    // Advance the model across one rising edge, using the inputs applied before it.
    task automatic model_update();
        logic [N-1:0] rose;
        logic [N-1:0] take;
        bit           sample;
        int           j;
        if (!rst_n) begin
            m_cyc = 0; m_seen1 = '0; m_seen2 = '0; m_lvl = '0; m_lvl_prev = '0;
            m_pend = '0; m_valid = 1'b0; m_id = '0; m_ovr = 1'b0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            sample = (m_cyc % TD) == (TD - 1);
            m_cyc++;
            rose = m_lvl & ~m_lvl_prev;
            m_lvl_prev = m_lvl;
            if (sample) begin
                for (int i = 0; i < N; i++) begin
                    if (m_seen2[i] !== m_lvl[i]) begin
                        m_run[i]++;
                        if (m_run[i] == EST) begin
                            m_lvl[i] = ~m_lvl[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            m_seen2 = m_seen1;
            m_seen1 = bus.botones0;
            take = '0;
            if (!m_valid) begin
                j = -1;
                for (int i = N - 1; i >= 0; i--) if (m_pend[i]) j = i;
                if (j >= 0) begin
                    take[j] = 1'b1;
                    m_id    = IDW'(j);
                    m_valid = 1'b1;
                end
            end else if (bus.evento_ready) begin
                m_valid = 1'b0;
            end
            m_ovr  = |(rose & m_pend & ~take);
            m_pend = (m_pend & ~take) | rose;
        end
    endtask

    // One clock: edge, model update, sample on the falling edge, tally observations.
    task automatic step();
        logic           pv, pr;
        logic [IDW-1:0] pid;
        bit             in_rst;
        pv = bus.evento_valid; pr = bus.evento_ready; pid = bus.evento_id; in_rst = !rst_n;
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (dut_vec() !== mdl_vec()) begin
            if (mm_n == 0) begin mm_got = dut_vec(); mm_exp = mdl_vec(); mm_t = $time; end
            mm_n++;
        end
        if (!in_rst && rst_n && pv === 1'b1 && pr === 1'b0 &&
            (bus.evento_valid !== 1'b1 || bus.evento_id !== pid)) hs_n++;
        if (bus.overrun === 1'b1) ovr_n++;
    endtask

    task automatic clear_tallies();
        mm_n = 0; hs_n = 0; ovr_n = 0;
    endtask

    task automatic wait_lvl(input int idx, input logic val, input int budget, output int n);
        n = -1;
        for (int c = 1; c <= budget; c++) begin
            step();
            if (bus.botones[idx] === val) begin n = c; break; end
        end
    endtask

    task automatic test_reset();
        int vcnt;
        clear_tallies();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.botones0 = N'($urandom);
            step();
            total++;
            if (dut_vec() !== '0) begin
                bad++; $display("FAIL reset_outputs got=%h required=0", dut_vec());
            end
        end
        bus.botones0 = '0;
        rst_n = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (bus.evento_valid !== 1'b0) vcnt++;
        end
        total++;
        if (vcnt !== 0) begin bad++; $display("FAIL reset_quiet_valid got=%0d required=0", vcnt); end
        total++;
        if (ovr_n !== 0) begin bad++; $display("FAIL reset_quiet_overrun got=%0d required=0", ovr_n); end
        total++;
        if (mm_n !== 0) begin
            bad++; $display("FAIL reset_model n=%0d t=%0t got=%h exp=%h", mm_n, mm_t, mm_got, mm_exp);
        end
    endtask

    task automatic test_press0();
        int n, hold_bad;
        clear_tallies();
        bus.evento_ready = 1'b0;
        bus.botones0[0]  = 1'b1;
        wait_lvl(0, 1'b1, 100, n);
        total++;
        if (n < 0) begin bad++; $display("FAIL press0_level got=timeout required=rise"); end
        n = 0;
        while (bus.evento_valid !== 1'b1 && n < 10) begin step(); n++; end
        total++;
        if (n !== 2) begin bad++; $display("FAIL press0_latency got=%0d required=2", n); end
        total++;
        if (bus.evento_id !== 2'd0) begin bad++; $display("FAIL press0_id got=%0d required=0", bus.evento_id); end
        hold_bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.evento_valid !== 1'b1 || bus.evento_id !== 2'd0) hold_bad++;
        end
        total++;
        if (hold_bad !== 0) begin bad++; $display("FAIL press0_hold got=%0d required=0", hold_bad); end
        bus.evento_ready = 1'b1;
        step();
        bus.evento_ready = 1'b0;
        total++;
        if (bus.evento_valid !== 1'b0) begin
            bad++; $display("FAIL press0_accept got=%b required=0", bus.evento_valid);
        end
        bus.botones0[0] = 1'b0;
        for (int k = 0; k < 40; k++) step();
        total++;
        if (mm_n !== 0 || hs_n !== 0) begin
            bad++; $display("FAIL press0_model n=%0d hs=%0d t=%0t got=%h exp=%h", mm_n, hs_n, mm_t, mm_got, mm_exp);
        end
    endtask

    task automatic test_bounce();
        int errs;
        clear_tallies();
        errs = 0;
        for (int c = 0; c < 200; c++) begin
            if (c % 5 == 0) bus.botones0[1] = ~bus.botones0[1];
            step();
            if (bus.botones[1] !== 1'b0 || bus.evento_valid !== 1'b0) errs++;
        end
        for (int k = 0; k < 10; k++) step();
        total++;
        if (errs !== 0) begin bad++; $display("FAIL bounce_quiet got=%0d required=0", errs); end
        total++;
        if (mm_n !== 0) begin
            bad++; $display("FAIL bounce_model n=%0d t=%0t got=%h exp=%h", mm_n, mm_t, mm_got, mm_exp);
        end
    endtask

    task automatic test_simul();
        int ids[$];
        int cyc[$];
        clear_tallies();
        bus.evento_ready = 1'b1;
        bus.botones0[2:1] = 2'b11;
        for (int c = 0; c < 100; c++) begin
            step();
            if (bus.evento_valid === 1'b1) begin ids.push_back(int'(bus.evento_id)); cyc.push_back(c); end
        end
        total++;
        if (ids.size() !== 2) begin
            bad++; $display("FAIL simul_count got=%0d required=2", ids.size());
        end else begin
            total++;
            if (ids[0] !== 1 || ids[1] !== 2) begin
                bad++; $display("FAIL simul_order got=%0d,%0d required=1,2", ids[0], ids[1]);
            end
            total++;
            if (cyc[1] - cyc[0] < 2) begin
                bad++; $display("FAIL simul_gap got=%0d required>=2", cyc[1] - cyc[0]);
            end
        end
        bus.botones0[2:1] = 2'b00;
        bus.evento_ready  = 1'b0;
        for (int k = 0; k < 30; k++) step();
        total++;
        if (mm_n !== 0) begin
            bad++; $display("FAIL simul_model n=%0d t=%0t got=%h exp=%h", mm_n, mm_t, mm_got, mm_exp);
        end
    endtask

    task automatic test_overrun();
        int n, ev, to;
        clear_tallies();
        to = 0;
        bus.evento_ready = 1'b0;
        bus.botones0[3]  = 1'b1;
        wait_lvl(3, 1'b1, 100, n); if (n < 0) to++;
        for (int k = 0; k < 3; k++) step();
        total++;
        if (bus.evento_valid !== 1'b1 || bus.evento_id !== 2'd3) begin
            bad++; $display("FAIL ovr_first_offer got=%b/%0d required=1/3", bus.evento_valid, bus.evento_id);
        end
        for (int p = 0; p < 2; p++) begin
            bus.botones0[3] = 1'b0;
            wait_lvl(3, 1'b0, 100, n); if (n < 0) to++;
            bus.botones0[3] = 1'b1;
            wait_lvl(3, 1'b1, 100, n); if (n < 0) to++;
            for (int k = 0; k < 4; k++) step();
        end
        total++;
        if (to !== 0) begin bad++; $display("FAIL ovr_timeouts got=%0d required=0", to); end
        total++;
        if (ovr_n !== 1) begin bad++; $display("FAIL ovr_pulse got=%0d required=1", ovr_n); end
        bus.evento_ready = 1'b1;
        ev = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus.evento_valid === 1'b1 && bus.evento_id === 2'd3) ev++;
            step();
        end
        total++;
        if (ev !== 2) begin bad++; $display("FAIL ovr_events got=%0d required=2", ev); end
        bus.botones0[3]  = 1'b0;
        bus.evento_ready = 1'b0;
        for (int k = 0; k < 30; k++) step();
        total++;
        if (mm_n !== 0 || hs_n !== 0) begin
            bad++; $display("FAIL ovr_model n=%0d hs=%0d t=%0t got=%h exp=%h", mm_n, hs_n, mm_t, mm_got, mm_exp);
        end
    endtask

    task automatic test_random();
        int b, hold;
        clear_tallies();
        for (int seg = 0; seg < 60; seg++) begin
            b    = $urandom_range(0, N - 1);
            hold = $urandom_range(1, 25);
            bus.botones0[b] = ~bus.botones0[b];
            for (int k = 0; k < hold; k++) begin
                bus.evento_ready = 1'($urandom_range(0, 1));
                step();
            end
        end
        bus.botones0     = '0;
        bus.evento_ready = 1'b1;
        for (int k = 0; k < 80; k++) step();
        bus.evento_ready = 1'b0;
        total++;
        if (mm_n !== 0) begin
            bad++; $display("FAIL random_model n=%0d t=%0t got=%h exp=%h", mm_n, mm_t, mm_got, mm_exp);
        end
        total++;
        if (hs_n !== 0) begin bad++; $display("FAIL random_handshake got=%0d required=0", hs_n); end
    endtask

    task automatic test_reset_offer();
        int n, vcnt;
        clear_tallies();
        bus.evento_ready = 1'b0;
        bus.botones0     = 4'b0101;
        wait_lvl(2, 1'b1, 100, n);
        for (int k = 0; k < 4; k++) step();
        total++;
        if (n < 0 || bus.evento_valid !== 1'b1 || bus.evento_id !== 2'd0) begin
            bad++; $display("FAIL roff_offer got=%b/%0d required=1/0", bus.evento_valid, bus.evento_id);
        end
        rst_n        = 1'b0;
        bus.botones0 = '0;
        step();
        rst_n = 1'b1;
        total++;
        if (dut_vec() !== '0) begin bad++; $display("FAIL roff_reset got=%h required=0", dut_vec()); end
        vcnt = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (bus.evento_valid !== 1'b0) vcnt++;
        end
        total++;
        if (vcnt !== 0) begin bad++; $display("FAIL roff_no_event got=%0d required=0", vcnt); end
        total++;
        if (mm_n !== 0) begin
            bad++; $display("FAIL roff_model n=%0d t=%0t got=%h exp=%h", mm_n, mm_t, mm_got, mm_exp);
        end
    endtask

    initial begin
        bus.botones0     = '0;
        bus.evento_ready = 1'b0;
        test_reset();
        test_press0();
        test_bounce();
        test_simul();
        test_overrun();
        test_random();
        test_reset_offer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boton_ctrl.md
# boton_ctrl

Multi-button input controller that sequences debounce filtering for N raw push-buttons and arbitrates their press events onto a single valid/ready event port. It sits between the board's raw button pins and the consuming control FSM. It replaces ad-hoc per-button filters with one shared sample-tick prescaler, N stability counters, and one fixed-priority event arbiter.

## Interface
Parameters:
- N_BOTONES, 4: number of buttons, 2..8.
- TICK_DIV, 50000: clock cycles per sample tick, ≥2.
- ESTABLE, 4: consecutive differing ticks required to flip a debounced level, 1..15.

Ports:
- Clk  in  1  single clock; all logic on rising edge.
- Reset_n  in  1  reset, synchronous, active-low.
- botones0  in  N_BOTONES  raw asynchronous button inputs, 1 = pressed.
- botones  out  N_BOTONES  debounced levels.
- evento_valid  out  1  press event offered.
- evento_id  out  clog2(N_BOTONES)  index of the offered button; a width of at least 1 is used.
- evento_ready  in  1  consumer accepts the event.
- overrun  out  1  one-cycle pulse when a press is lost.

## Operation
- Each botones0 bit passes through a two-flop synchronizer to give s[i].
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` is asserted for one cycle when count == TICK_DIV-1.
- Per-button filter, evaluated on tick only:
  - If s[i] != botones[i], increment cnt[i].
  - If s[i] == botones[i], clear cnt[i].
  - When the increment would make cnt[i] == ESTABLE, toggle botones[i] and clear cnt[i].
- Edge detect:
  - botones_d registers botones.
  - A rise on bit i (botones & ~botones_d) sets pending[i] one edge after the level flips.
- Arbiter states:
  - IDLE: if pending != 0, pick the lowest set index. On the same edge, latch evento_id, clear that pending bit, assert evento_valid, and go to OFFER.
  - OFFER: hold evento_valid = 1 and keep evento_id stable. When evento_valid && evento_ready, deassert valid and return to IDLE.
  - A new offer can start at the earliest on the edge after return to IDLE, so peak throughput is one event per 2 cycles.
- Set/clear collisions:
  - A rise on a bit whose pending is already 1 leaves pending at 1 and pulses overrun for one cycle.
  - A rise on bit i on the same edge that IDLE clears pending[i] means set wins: pending[i] = 1 and no overrun.
  - A rise on the bit currently offered in OFFER sets pending normally, with no overrun.
- Releases (falling debounced edges) generate no event.

## Timing
- Reset (Reset_n = 0 at an edge):
  - botones, evento_valid, evento_id and overrun are 0.
  - Synchronizers, prescaler, cnt, botones_d and pending are all cleared; state is IDLE.
  - Reset mid-OFFER drops the event: valid = 0 on that edge and pending is cleared.
- Raw-to-level latency: the input is seen at s[i] 2 edges after it changes. botones[i] flips on the ESTABLE-th consecutive tick with s[i] != botones[i].
- Level-to-event latency: with the arbiter in IDLE and no higher-priority pending, evento_valid rises 2 edges after botones[i] rises.
- Handshake:
  - evento_valid never drops without evento_ready.
  - evento_id never changes while valid.
  - evento_ready while valid is 0 is ignored.
- Prescaler free-runs in all states; button activity does not realign it.

## Structure
- Shared package `boton_pkg` holds:
  - the arbiter state enum {IDLE, OFFER};
  - the ID_W width function (clog2 with a minimum of 1);
  - the CNT_W constant (4 bits, covering ESTABLE ≤ 15).
- Sub-module `boton_filtro` is instantiated N_BOTONES times. It contains the synchronizer, stability counter and level register, and takes `tick` as an input.
- Prescaler, edge detect, pending register and arbiter live in boton_ctrl.

## Test plan
Simulation parameters for all scenarios: TICK_DIV=4, ESTABLE=3, Clk period 20 ns.
1. Reset: hold Reset_n = 0 for 2 edges with random inputs → all outputs 0. Release → overrun stays 0 and no event appears with quiet inputs.
2. Clean press on button 0:
   - Drive botones0[0] = 1 and hold it → botones[0] rises on the 3rd tick seen after sync; evento_valid = 1 with id 0 two edges later.
   - Hold ready = 0 for 10 cycles → valid and id are stable.
   - Pulse ready = 1 → valid = 0 on the next edge.
3. Bounce: toggle botones0[1] every 5 cycles for 200 cycles → botones[1] stays 0 and evento_valid is never asserted.
4. Simultaneous press: raise buttons 1 and 2 in the same cycle with ready tied to 1 → events are delivered as id 1, then id 2, at least 2 cycles apart.
5. Overrun on button 3 with ready = 0:
   - Press → offered as id 3.
   - Release and press again → pending set.
   - Release and press a third time → overrun pulses for exactly 1 cycle.
   - Then set ready = 1 → exactly two id-3 events in total.
6. Reset mid-offer: while evento_valid = 1 with id 2 pending behind it, pull Reset_n low for 1 edge → valid = 0 and no event after release.
